// File: rtl/carfield_chip_pkg.sv
// ----------------------------------------------------------------------------
// carfield_chip_pkg
//
// Shared chip-level constants and types.
//   - CarfieldPllJtagIdCode : the IDCODE held by the Carfield PLL TAP. This is
//                             the single source for the expected code.
//   - JtagTlrCycles         : TCK periods with TMS=1 that force Test-Logic-Reset.
//   - JtagIdcodeLen         : number of IDCODE bits shifted out of Shift-DR.
//   - JtagTrstCycles        : TCK periods TRST is held low (optional TRST build).
//   - jtag_probe_state_e    : sequencer states of the IDCODE probe.
//   - jtag_idcode_implausible() : flags codes that cannot come from a real TAP.
// ----------------------------------------------------------------------------
package carfield_chip_pkg;

    localparam logic [31:0] CarfieldPllJtagIdCode = 32'h1abc0db3;

    localparam int unsigned JtagTlrCycles  = 5;
    localparam int unsigned JtagIdcodeLen  = 32;
    localparam int unsigned JtagTrstCycles = 2;

    // Width of the per-state period counter and of the TCK divider counter.
    localparam int unsigned JtagCntWidth = 6;
    localparam int unsigned JtagDivWidth = 8;

    typedef enum logic [3:0] {
        StIdle,
        StTrst,
        StTlrSeq,
        StRti,
        StSelDr,
        StCapDr,
        StEnterShift,
        StShift,
        StExit1,
        StUpdate,
        StDone
    } jtag_probe_state_e;

    // A valid IDCODE always has bit 0 set; all-ones means TDO floated high.
    function automatic logic jtag_idcode_implausible(input logic [31:0] code);
        return (code[0] == 1'b0) || (code == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/carfield_jtag_tck_gen.sv
// ----------------------------------------------------------------------------
// carfield_jtag_tck_gen
//
// TCK divider for the JTAG IDCODE probe. While en_i is high, TCK toggles every
// TckDiv clk_i cycles, starting with a low phase; while en_i is low TCK idles
// low and the divider is held at zero.
//
// Ports:
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset
//   en_i    in  run the divider
//   tck_o   out registered JTAG TCK
//   rise_o  out high in the clk_i cycle whose closing edge raises TCK
//   fall_o  out high in the clk_i cycle whose closing edge lowers TCK
//
// TckDiv legal range is 1..255.
// ----------------------------------------------------------------------------
module carfield_jtag_tck_gen
    import carfield_chip_pkg::*;
#(
    parameter int unsigned TckDiv = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [JtagDivWidth-1:0] DivLast = JtagDivWidth'(TckDiv - 1);

    logic [JtagDivWidth-1:0] r_div_cnt;
    logic                    r_tck;
    logic                    w_phase_end;

    assign w_phase_end = en_i && (r_div_cnt == DivLast);
    assign rise_o      = w_phase_end && !r_tck;
    assign fall_o      = w_phase_end && r_tck;
    assign tck_o       = r_tck;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div_cnt <= '0;
            r_tck     <= 1'b0;
        end else if (!en_i) begin
            r_div_cnt <= '0;
            r_tck     <= 1'b0;
        end else if (w_phase_end) begin
            // Reload on every phase boundary.
            r_div_cnt <= '0;
            r_tck     <= ~r_tck;
        end else begin
            r_div_cnt <= r_div_cnt + JtagDivWidth'(1);
        end
    end

endmodule

// File: rtl/carfield_jtag_idcode_probe.sv
// ----------------------------------------------------------------------------
// carfield_jtag_idcode_probe
//
// On-chip JTAG host that walks the PLL TAP from any state through
// Test-Logic-Reset into Shift-DR, shifts out the 32-bit IDCODE (loaded by
// Test-Logic-Reset), parks the TAP in Run-Test/Idle and reports the result.
//
// Ports:
//   clk_i        in  system clock (host domain)
//   rst_ni       in  asynchronous active-low reset
//   start_i      in  single-cycle request; accepted only in IDLE
//   busy_o       out high while a read sequence is running
//   done_o       out one-cycle pulse when a sequence completes
//   idcode_o     out captured IDCODE, held until the next accepted start
//   match_o      out idcode_o == ExpectedIdCode, held
//   error_o      out idcode_o[0]==0 or idcode_o all ones, held
//   jtag_tck_o   out JTAG TCK, low when idle
//   jtag_tms_o   out JTAG TMS, changes only on TCK falling edges
//   jtag_tdi_o   out JTAG TDI, constant 0
//   jtag_trst_no out JTAG TRST (active low)
//   jtag_tdo_i   in  JTAG TDO, already synchronous to clk_i
//
// Build option: define CARFIELD_JTAG_PROBE_TRST_EN to pulse TRST low for
// JtagTrstCycles TCK periods before the TMS reset sequence. Without it TRST is
// tied high.
//
// Sequence length: 43 TCK periods (45 with TRST), then one DONE cycle.
// ----------------------------------------------------------------------------
module carfield_jtag_idcode_probe
    import carfield_chip_pkg::*;
#(
    parameter logic [31:0] ExpectedIdCode = CarfieldPllJtagIdCode,
    parameter int unsigned TckDiv         = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] idcode_o,
    output logic        match_o,
    output logic        error_o,
    output logic        jtag_tck_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    output logic        jtag_trst_no,
    input  logic        jtag_tdo_i
);

    localparam logic [JtagCntWidth-1:0] TlrLast   = JtagCntWidth'(JtagTlrCycles - 1);
    localparam logic [JtagCntWidth-1:0] ShiftLast = JtagCntWidth'(JtagIdcodeLen - 1);
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
    localparam logic [JtagCntWidth-1:0] TrstLast  = JtagCntWidth'(JtagTrstCycles - 1);
`endif

    jtag_probe_state_e       r_state;
    logic [JtagCntWidth-1:0] r_cnt;
    logic [31:0]             r_shift;
    logic                    r_busy;
    logic                    r_done;
    logic [31:0]             r_idcode;
    logic                    r_match;
    logic                    r_error;
    logic                    r_tms;
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
    logic                    r_trst_n;
`endif

    logic                    w_tck;
    logic                    w_rise;
    logic                    w_fall;
    logic [JtagCntWidth-1:0] w_cnt_inc;

    // Period counter saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == {JtagCntWidth{1'b1}}) ? r_cnt : r_cnt + JtagCntWidth'(1);

    carfield_jtag_tck_gen #(
        .TckDiv (TckDiv)
    ) u_tck_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (r_busy),
        .tck_o  (w_tck),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    // Each state owns whole TCK periods: it is entered on a falling edge (or on
    // start acceptance) and the TMS it drives is seen by the TAP on the rising
    // edge in the middle of that period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idcode <= '0;
            r_match  <= 1'b0;
            r_error  <= 1'b0;
            r_tms    <= 1'b1;
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
            r_trst_n <= 1'b1;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_busy   <= 1'b1;
                        r_idcode <= '0;
                        r_match  <= 1'b0;
                        r_error  <= 1'b0;
                        r_cnt    <= '0;
                        r_tms    <= 1'b1;
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
                        r_state  <= StTrst;
                        r_trst_n <= 1'b0;
`else
                        r_state  <= StTlrSeq;
`endif
                    end
                end
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
                StTrst: begin
                    if (w_fall) begin
                        if (r_cnt == TrstLast) begin
                            r_state  <= StTlrSeq;
                            r_cnt    <= '0;
                            r_trst_n <= 1'b1;
                            r_tms    <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
`endif
                StTlrSeq: begin
                    if (w_fall) begin
                        if (r_cnt == TlrLast) begin
                            r_state <= StRti;
                            r_cnt   <= '0;
                            r_tms   <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                StRti: begin
                    if (w_fall) begin
                        r_state <= StSelDr;
                        r_tms   <= 1'b1;
                    end
                end
                StSelDr: begin
                    if (w_fall) begin
                        r_state <= StCapDr;
                        r_tms   <= 1'b0;
                    end
                end
                StCapDr: begin
                    if (w_fall) begin
                        r_state <= StEnterShift;
                        r_tms   <= 1'b0;
                    end
                end
                StEnterShift: begin
                    // The rise in this period moves the TAP into Shift-DR.
                    if (w_fall) begin
                        r_state <= StShift;
                        r_cnt   <= '0;
                        r_tms   <= 1'b0;
                    end
                end
                StShift: begin
                    // LSB arrives first, so shift in from the top.
                    if (w_rise) begin
                        r_shift <= {jtag_tdo_i, r_shift[31:1]};
                    end
                    if (w_fall) begin
                        if (r_cnt == ShiftLast) begin
                            r_state <= StExit1;
                            r_cnt   <= '0;
                            r_tms   <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            // TMS=1 on the last bit leaves Shift-DR after it.
                            r_tms <= (w_cnt_inc == ShiftLast);
                        end
                    end
                end
                StExit1: begin
                    if (w_fall) begin
                        r_state <= StUpdate;
                        r_tms   <= 1'b0;
                    end
                end
                StUpdate: begin
                    if (w_fall) begin
                        r_state  <= StDone;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_idcode <= r_shift;
                        r_match  <= (r_shift == ExpectedIdCode);
                        r_error  <= jtag_idcode_implausible(r_shift);
                        // TCK stops here, so TMS can return to its idle level.
                        r_tms    <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign idcode_o   = r_idcode;
    assign match_o    = r_match;
    assign error_o    = r_error;
    assign jtag_tck_o = w_tck;
    assign jtag_tms_o = r_tms;
    assign jtag_tdi_o = 1'b0;
`ifdef CARFIELD_JTAG_PROBE_TRST_EN
    assign jtag_trst_no = r_trst_n;
`else
    assign jtag_trst_no = 1'b1;
`endif

endmodule
